// File: rtl/scroll_display_mux.sv
// Purpose: multiplexed 7-segment driver that scans digits and shows rotated, scrolling or blinking patterns.
// Latency: trans/led7seg are registered one cycle after scan_idx; offset/step update on the step-timer wrap.
// Backpressure: none; free-running display scan, enable=0 or rst=1 darkens the display and clears all counters.
module scroll_display_mux #(
    parameter int NUM_DIGITS = 7,
    parameter int SCAN_DIV   = 25000,
    parameter int BASE_DIV   = 50000000
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            enable,
    input  logic [1:0]                      mode,
    input  logic [1:0]                      speed,
    input  logic [7*NUM_DIGITS-1:0]         chars,
    output logic [NUM_DIGITS-1:0]           trans,
    output logic [6:0]                      led7seg,
    output logic [$clog2(NUM_DIGITS)-1:0]   offset,
    output logic                            step
);

    localparam int IW = $clog2(NUM_DIGITS);
    localparam int SW = $clog2(SCAN_DIV + 1);
    localparam int CW = $clog2(BASE_DIV + 1);

    localparam logic [IW:0]   NDIG      = (IW + 1)'(NUM_DIGITS);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_DIGITS - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BASE_CNT  = CW'(BASE_DIV);

    localparam logic [1:0] MODE_STATIC = 2'b00;
    localparam logic [1:0] MODE_LEFT   = 2'b01;
    localparam logic [1:0] MODE_RIGHT  = 2'b10;
    localparam logic [1:0] MODE_BLINK  = 2'b11;

    logic [SW-1:0]         scan_cnt;
    logic [IW-1:0]         scan_idx;
    logic [CW-1:0]         step_cnt;
    logic                  blank;

    logic                  clear;
    logic [CW-1:0]         step_lim;
    logic                  step_hit;
    logic [IW:0]           off_inc;
    logic [IW-1:0]         off_up;
    logic [IW-1:0]         off_dn;
    logic [IW:0]           digit_sum;
    logic                  digit_wrap;
    logic [IW-1:0]         digit_sel;
    logic [6:0]            seg_sel;
    logic [NUM_DIGITS-1:0] trans_nxt;

    assign clear = rst || !enable;

    // Step period shrinks by powers of two; the compare is done one bit wider so a
    // period that shrinks below the current count fires immediately without overflow.
    assign step_lim = BASE_CNT >> speed;
    assign step_hit = ({1'b0, step_cnt} + (CW + 1)'(1)) >= {1'b0, step_lim};

    // Rotation offset neighbours, wrapping inside 0..NUM_DIGITS-1 for any digit count.
    assign off_inc = {1'b0, offset} + (IW + 1)'(1);
    assign off_up  = (off_inc >= NDIG) ? '0 : off_inc[IW-1:0];
    assign off_dn  = (offset == '0) ? LAST_IDX : offset - IW'(1);

    // Digit shown in the current slot: (scan_idx + offset) mod NUM_DIGITS on a widened sum.
    assign digit_sum  = {1'b0, scan_idx} + {1'b0, offset};
    assign digit_wrap = digit_sum >= NDIG;
    assign digit_sel  = digit_sum[IW-1:0] - (digit_wrap ? IW'(NUM_DIGITS) : IW'(0));

    // Pattern mux; an explicit compare per digit keeps non-power-of-2 counts in range.
    always_comb begin
        seg_sel = 7'h7F;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (digit_sel == IW'(k)) begin
                seg_sel = chars[7*k +: 7];
            end
        end
    end

    // One-cold digit select, digit 0 driven on the MSB.
    always_comb begin
        trans_nxt = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (scan_idx == IW'(NUM_DIGITS - 1 - k)) begin
                trans_nxt[k] = 1'b0;
            end
        end
    end

    // Scan slot timer and digit index.
    always_ff @(posedge clk) begin
        if (clear) begin
            scan_cnt <= '0;
            scan_idx <= '0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            scan_idx <= (scan_idx == LAST_IDX) ? '0 : scan_idx + IW'(1);
        end else begin
            scan_cnt <= scan_cnt + SW'(1);
        end
    end

    // Output register: digit select and segments always come from the same scan_idx.
    always_ff @(posedge clk) begin
        if (clear) begin
            trans   <= '1;
            led7seg <= 7'h7F;
        end else begin
            trans   <= trans_nxt;
            led7seg <= blank ? 7'h7F : seg_sel;
        end
    end

    // Step timer driving scroll offset and blink phase.
    always_ff @(posedge clk) begin
        if (clear) begin
            step_cnt <= '0;
            offset   <= '0;
            blank    <= 1'b0;
            step     <= 1'b0;
        end else if (mode == MODE_STATIC) begin
            step_cnt <= '0;
            offset   <= '0;
            blank    <= 1'b0;
            step     <= 1'b0;
        end else if (step_hit) begin
            step_cnt <= '0;
            step     <= 1'b1;
            if (mode == MODE_LEFT) begin
                offset <= off_up;
            end else if (mode == MODE_RIGHT) begin
                offset <= off_dn;
            end
            blank <= (mode == MODE_BLINK) ? !blank : 1'b0;
        end else begin
            step_cnt <= step_cnt + CW'(1);
            step     <= 1'b0;
            blank    <= (mode == MODE_BLINK) ? blank : 1'b0;
        end
    end

endmodule

// File: tb/tb_scroll_display_mux.sv
// Bench for scroll_display_mux with NUM_DIGITS=4, SCAN_DIV=4, BASE_DIV=64.
// Expected outputs come from a cycle model of the display behaviour and go through a queue.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_scroll_display_mux;

    localparam int N     = 4;
    localparam int SCAN  = 4;
    localparam int BASE  = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [1:0]  mode;
    logic [1:0]  speed;
    logic [27:0] chars;
    logic [3:0]  trans;
    logic [6:0]  led7seg;
    logic [1:0]  offset;
    logic        step;

    always #5 clk = ~clk;

    scroll_display_mux #(
        .NUM_DIGITS (N),
        .SCAN_DIV   (SCAN),
        .BASE_DIV   (BASE)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .mode    (mode),
        .speed   (speed),
        .chars   (chars),
        .trans   (trans),
        .led7seg (led7seg),
        .offset  (offset),
        .step    (step)
    );

    typedef struct packed {
        logic [3:0] tr;
        logic [6:0] led;
        logic [1:0] off;
        logic       stp;
    } exp_t;

    exp_t sbq[$];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Reference state: cycles since restart, step count, rotation, blink phase.
    int         m_i;
    int         m_cnt;
    logic [1:0] m_off;
    logic       m_blank;

    function automatic logic [6:0] char_of(int d);
        return chars[d*7 +: 7];
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Predict the outputs for the coming edge from the inputs currently driven.
    task automatic model_push();
        exp_t e;
        int   slot;
        int   p;
        logic fire;
        if (rst || !enable) begin
            e.tr  = 4'hF;
            e.led = 7'h7F;
            e.off = 2'd0;
            e.stp = 1'b0;
            m_i     = 0;
            m_cnt   = 0;
            m_off   = 2'd0;
            m_blank = 1'b0;
        end else begin
            slot  = (m_i / SCAN) % N;
            e.tr  = ~(4'b1000 >> slot);
            e.led = m_blank ? 7'h7F : char_of((slot + int'(m_off)) % N);
            p     = BASE >> speed;
            fire  = 1'b0;
            if (mode == 2'b00) begin
                m_cnt   = 0;
                m_off   = 2'd0;
                m_blank = 1'b0;
            end else if (m_cnt >= p - 1) begin
                fire  = 1'b1;
                m_cnt = 0;
                if (mode == 2'b01) m_off = 2'((int'(m_off) + 1) % N);
                if (mode == 2'b10) m_off = 2'((int'(m_off) + N - 1) % N);
                m_blank = (mode == 2'b11) ? !m_blank : 1'b0;
            end else begin
                m_cnt++;
                if (mode != 2'b11) m_blank = 1'b0;
            end
            e.off = m_off;
            e.stp = fire;
            m_i++;
        end
        sbq.push_back(e);
    endtask

    task automatic check_out(string tag);
        exp_t e;
        if (sbq.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s_sb_empty cyc=%0d got=0 want=1", tag, cyc);
        end else begin
            e = sbq.pop_front();
            chk({tag, "_trans"}, 32'(trans),   32'(e.tr));
            chk({tag, "_led"},   32'(led7seg), 32'(e.led));
            chk({tag, "_off"},   32'(offset),  32'(e.off));
            chk({tag, "_step"},  32'(step),    32'(e.stp));
        end
    endtask

    task automatic run(string tag, int n, logic r, logic en, logic [1:0] m, logic [1:0] s);
        rst    = r;
        enable = en;
        mode   = m;
        speed  = s;
        for (int j = 0; j < n; j++) begin
            model_push();
            @(posedge clk);
            #1;
            cyc++;
            check_out(tag);
        end
    endtask

    initial begin
        rst     = 1'b1;
        enable  = 1'b0;
        mode    = 2'b00;
        speed   = 2'b00;
        chars   = {7'h08, 7'h03, 7'h46, 7'h21};
        m_i     = 0;
        m_cnt   = 0;
        m_off   = 2'd0;
        m_blank = 1'b0;

        // Reset held, then disabled: display dark, offset 0.
        run("rst",      3,  1'b1, 1'b0, 2'b00, 2'b00);
        run("dis",      20, 1'b0, 1'b0, 2'b00, 2'b00);

        // Static scan of two full frames, then a pattern change picked up on rescan.
        run("static",   32, 1'b0, 1'b1, 2'b00, 2'b00);
        chars = {7'h08, 7'h12, 7'h46, 7'h21};
        run("chars",    16, 1'b0, 1'b1, 2'b00, 2'b00);

        // Scroll left at the slowest rate through a full rotation.
        run("restart",  1,  1'b0, 1'b0, 2'b01, 2'b00);
        run("left",     260, 1'b0, 1'b1, 2'b01, 2'b00);

        // Scroll right at the fastest rate through a full rotation.
        run("restart",  1,  1'b0, 1'b0, 2'b10, 2'b11);
        run("right",    40, 1'b0, 1'b1, 2'b10, 2'b11);

        // Right to offset 2, then left keeps the offset and continues 3, 0.
        run("restart",  1,  1'b0, 1'b0, 2'b10, 2'b11);
        run("right2",   16, 1'b0, 1'b1, 2'b10, 2'b11);
        run("swleft",   16, 1'b0, 1'b1, 2'b01, 2'b11);

        // Blink every 16 cycles; leave blink while blanked, patterns return.
        run("restart",  1,  1'b0, 1'b0, 2'b11, 2'b10);
        run("blink",    48, 1'b0, 1'b1, 2'b11, 2'b10);
        run("unblink",  3,  1'b0, 1'b1, 2'b00, 2'b10);

        // Speed shortened with step_cnt at 40: step fires on the next edge.
        run("restart",  1,  1'b0, 1'b0, 2'b01, 2'b00);
        run("slow",     40, 1'b0, 1'b1, 2'b01, 2'b00);
        run("fast",     10, 1'b0, 1'b1, 2'b01, 2'b11);

        // Reset in the middle of a scroll, then resume from a clean start.
        run("scroll",   5,  1'b0, 1'b1, 2'b01, 2'b11);
        run("midrst",   1,  1'b1, 1'b1, 2'b01, 2'b11);
        run("resume",   12, 1'b0, 1'b1, 2'b01, 2'b11);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
